// File: rtl/mean_buf_pkg.sv
// Shared types and constants for the mean line buffer.
// Optional feature macro: MEAN_BUF_DROP_CNT_EN (dropped-write counter).
package mean_buf_pkg;

  // Lifecycle of one line bank: empty, being written, holding a complete line.
  typedef enum logic [1:0] {
    FREE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } bank_state_t;

  localparam int NUM_BANKS  = 2;
  localparam int DROP_CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mean_line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port.
// The address MSB selects the bank, the low bits select the pixel, so the
// storage is NUM_BANKS x LINE_WIDTH entries of MEAN_SIZE bits.
module mean_line_ram
  import mean_buf_pkg::*;
#(
  parameter int LINE_WIDTH     = 640,
  parameter int MEAN_SIZE      = 8,
  parameter int BUF_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [BUF_ADDR_WIDTH:0]   waddr,
  input  logic [MEAN_SIZE-1:0]      wdata,
  input  logic                      re,
  input  logic [BUF_ADDR_WIDTH:0]   raddr,
  output logic [MEAN_SIZE-1:0]      rdata
);

  localparam logic [BUF_ADDR_WIDTH:0] LW = (BUF_ADDR_WIDTH+1)'(LINE_WIDTH);

  logic [MEAN_SIZE-1:0] mem [NUM_BANKS][LINE_WIDTH];
  logic [MEAN_SIZE-1:0] rdata_q, rdata_d;
  logic                 rd_in_range;

  // Storage write; the caller only asserts we for in-range pixel addresses.
  always_ff @(posedge clk) begin
    if (we) mem[waddr[BUF_ADDR_WIDTH]][waddr[BUF_ADDR_WIDTH-1:0]] <= wdata;
  end

  // Read mux; addresses past the line end return zero rather than indexing off the array.
  always_comb begin
    rd_in_range = ({1'b0, raddr[BUF_ADDR_WIDTH-1:0]} < LW);
    rdata_d     = rdata_q;
    if (re) rdata_d = rd_in_range ? mem[raddr[BUF_ADDR_WIDTH]][raddr[BUF_ADDR_WIDTH-1:0]]
                                  : '0;
  end

  // Output register holds the last read; cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mean_line_buffer.sv
// Double-banked line buffer between the RGB-mean stage and the SAD engine.
// The write side fills one bank per line; the read side holds a FULL bank
// until sad_done releases it. wr_ready drops only while both banks are FULL.
// Optional feature macro: MEAN_BUF_DROP_CNT_EN adds the drop_count port.
module mean_line_buffer
  import mean_buf_pkg::*;
#(
  parameter int LINE_WIDTH     = 640,
  parameter int MEAN_SIZE      = 8,
  parameter int BUF_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MEAN_SIZE-1:0]       wr_data,
  input  logic [BUF_ADDR_WIDTH-1:0]  wr_addr,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic                       line_ready,
  input  logic                       rd_en,
  input  logic [BUF_ADDR_WIDTH-1:0]  rd_addr,
  output logic [MEAN_SIZE-1:0]       rd_data,
  output logic                       rd_valid,
  input  logic                       sad_done
`ifdef MEAN_BUF_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]      drop_count
`endif
);

  localparam logic [BUF_ADDR_WIDTH:0]   LW        = (BUF_ADDR_WIDTH+1)'(LINE_WIDTH);
  localparam logic [BUF_ADDR_WIDTH-1:0] LAST_ADDR = BUF_ADDR_WIDTH'(LINE_WIDTH-1);

  bank_state_t bank_q [NUM_BANKS];
  bank_state_t bank_d [NUM_BANKS];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ready_q, wr_ready_d;
  logic        line_ready_q, line_ready_d;
  logic        rd_valid_q, rd_valid_d;

  logic        wr_acc, wr_in_range, wr_store, wr_last, release_bank;

  // Bank state, pointer and registered-status next-state logic.
  // Registered flags are computed from the next state so they line up with it.
  always_comb begin
    wr_acc       = wr_valid & wr_ready_q;
    wr_in_range  = ({1'b0, wr_addr} < LW);
    wr_store     = wr_acc & wr_in_range;
    wr_last      = wr_store & (wr_addr == LAST_ADDR);
    release_bank = sad_done & line_ready_q;

    bank_d   = bank_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    // Completion is keyed on the last pixel only; order of other pixels is free.
    if (wr_store) begin
      if (wr_last) begin
        bank_d[wr_ptr_q] = FULL;
        wr_ptr_d         = ~wr_ptr_q;
      end else if (bank_q[wr_ptr_q] == FREE) begin
        bank_d[wr_ptr_q] = FILL;
      end
    end

    // A released bank is always the FULL read bank, which cannot be the one
    // accepting writes in the same cycle, so this never collides with the above.
    if (release_bank) begin
      bank_d[rd_ptr_q] = FREE;
      rd_ptr_d         = ~rd_ptr_q;
    end

    wr_ready_d   = (bank_d[wr_ptr_d] != FULL);
    line_ready_d = (bank_d[rd_ptr_d] == FULL);
    rd_valid_d   = rd_en;
  end

  // Control state registers; all banks and pointers return to empty on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_q[b] <= FREE;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      wr_ready_q   <= 1'b0;
      line_ready_q <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      bank_q       <= bank_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ready_q   <= wr_ready_d;
      line_ready_q <= line_ready_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign line_ready = line_ready_q;
  assign rd_valid   = rd_valid_q;

  mean_line_ram #(
    .LINE_WIDTH     (LINE_WIDTH),
    .MEAN_SIZE      (MEAN_SIZE),
    .BUF_ADDR_WIDTH (BUF_ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_store),
    .waddr ({wr_ptr_q, wr_addr}),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr ({rd_ptr_q, rd_addr}),
    .rdata (rd_data)
  );

`ifdef MEAN_BUF_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Count every cycle the mean stage offers a write that cannot be taken.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (wr_valid & ~wr_ready_q) drop_cnt_d = sat_inc(drop_cnt_q);
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mean_line_buffer.sv
// Directed bench for mean_line_buffer: table-driven short sequences plus
// hand-written line fills, reset and drop-counter corner cases.
module tb_mean_line_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wr_data;
  logic [9:0]  wr_addr;
  logic        wr_valid;
  logic        wr_ready;
  logic        line_ready;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        sad_done;
`ifdef MEAN_BUF_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mean_line_buffer #(
    .LINE_WIDTH     (640),
    .MEAN_SIZE      (8),
    .BUF_ADDR_WIDTH (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (wr_data),
    .wr_addr    (wr_addr),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .line_ready (line_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .sad_done   (sad_done)
`ifdef MEAN_BUF_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  typedef struct {
    logic       wv;
    logic [9:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [9:0] ra;
    logic       sd;
    logic       e_wrr;
    logic       e_lr;
    logic       e_rv;
    logic       cd;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vt [14];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; sad_done = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      wr_valid = vt[i].wv; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      rd_en = vt[i].re; rd_addr = vt[i].ra; sad_done = vt[i].sd;
      tick();
      chk($sformatf("vec%0d wr_ready", i), wr_ready, vt[i].e_wrr);
      chk($sformatf("vec%0d line_ready", i), line_ready, vt[i].e_lr);
      chk($sformatf("vec%0d rd_valid", i), rd_valid, vt[i].e_rv);
      if (vt[i].cd) chk($sformatf("vec%0d rd_data", i), rd_data, vt[i].e_rd);
    end
    idle();
  endtask

  // Write pixels 0..n-1 in order, data = addr[7:0] ^ seed.
  task automatic write_pixels(input int n, input logic [7:0] seed);
    for (int a = 0; a < n; a++) begin
      wr_valid = 1'b1;
      wr_addr  = 10'(a);
      wr_data  = 8'(a) ^ seed;
      tick();
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    //            wv    wa       wd     re    ra       sd    wrr   lr    rv    cd    rd
    // line 0 in bank 0 (data=addr), bank 1 free
    vt[0]  = '{1'b0, 10'd0,   8'h00, 1'b1, 10'd5,   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05};
    vt[1]  = '{1'b0, 10'd0,   8'h00, 1'b1, 10'd639, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h7F};
    vt[2]  = '{1'b0, 10'd0,   8'h00, 1'b0, 10'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    // both banks FULL: writes are dropped, then release both in turn
    vt[3]  = '{1'b1, 10'd10,  8'hFF, 1'b0, 10'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[4]  = '{1'b1, 10'd10,  8'hFF, 1'b0, 10'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[5]  = '{1'b1, 10'd10,  8'hFF, 1'b0, 10'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[6]  = '{1'b0, 10'd0,   8'h00, 1'b0, 10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[7]  = '{1'b0, 10'd0,   8'h00, 1'b1, 10'd5,   1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA0};
    vt[8]  = '{1'b0, 10'd0,   8'h00, 1'b0, 10'd0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    // sad_done with nothing FULL is ignored: read still targets bank 0
    vt[9]  = '{1'b0, 10'd0,   8'h00, 1'b0, 10'd0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[10] = '{1'b0, 10'd0,   8'h00, 1'b1, 10'd5,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05};
    // out-of-range write: handshake only
    vt[11] = '{1'b1, 10'd700, 8'hEE, 1'b0, 10'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    // after line seeded 3C: read pixel 100, then release
    vt[12] = '{1'b0, 10'd0,   8'h00, 1'b1, 10'd100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h58};
    vt[13] = '{1'b0, 10'd0,   8'h00, 1'b0, 10'd0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst wr_ready", wr_ready, 1'b0);
    chk("rst line_ready", line_ready, 1'b0);
    chk("rst rd_valid", rd_valid, 1'b0);
    chk("rst rd_data", rd_data, 8'h00);
`ifdef MEAN_BUF_DROP_CNT_EN
    chk("rst drop_count", drop_count, 16'd0);
`endif
    rst = 1'b0;
    tick();
    chk("post-rst wr_ready", wr_ready, 1'b1);

    // First line into bank 0; line_ready must stay low until the last pixel.
    write_pixels(639, 8'h00);
    chk("line0 partial line_ready", line_ready, 1'b0);
    wr_valid = 1'b1; wr_addr = 10'd639; wr_data = 8'h7F;
    tick();
    wr_valid = 1'b0;
    chk("line0 line_ready", line_ready, 1'b1);
    chk("line0 wr_ready", wr_ready, 1'b1);
    run_vecs(0, 2);

    // Second line into bank 1 without sad_done: both FULL.
    write_pixels(640, 8'hA5);
    chk("line1 wr_ready low", wr_ready, 1'b0);
    chk("line1 line_ready", line_ready, 1'b1);
    run_vecs(3, 5);
`ifdef MEAN_BUF_DROP_CNT_EN
    chk("drop_count 3", drop_count, 16'd3);
`endif
    run_vecs(6, 10);

    // Out-of-range pixel, then one full line into bank 0.
    run_vecs(11, 11);
    write_pixels(640, 8'h3C);
    chk("oor line_ready", line_ready, 1'b1);
    chk("oor one line only wr_ready", wr_ready, 1'b1);
    run_vecs(12, 13);

    // Mid-line reset: 300 pixels into bank 1, then rst.
    write_pixels(300, 8'h11);
    chk("mid-line line_ready", line_ready, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid rst wr_ready", wr_ready, 1'b0);
    chk("mid rst line_ready", line_ready, 1'b0);
`ifdef MEAN_BUF_DROP_CNT_EN
    chk("mid rst drop_count", drop_count, 16'd0);
`endif
    rst = 1'b0;
    tick();
    chk("mid post-rst wr_ready", wr_ready, 1'b1);
    write_pixels(640, 8'h5A);
    chk("fresh line_ready", line_ready, 1'b1);
    chk("fresh wr_ready", wr_ready, 1'b1);
    rd_en = 1'b1; rd_addr = 10'd639;
    tick();
    rd_en = 1'b0;
    chk("fresh rd_valid", rd_valid, 1'b1);
    chk("fresh rd_data", rd_data, 8'h25);
    tick();
    chk("fresh rd_valid low", rd_valid, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mean_line_buffer.md
# mean_line_buffer

Double-banked line buffer that sits directly downstream of the RGB-mean stage and upstream of the SAD engine. It accepts per-pixel mean values with write addresses and stores one camera line per bank. It tells the SAD engine when a complete line is available and releases a bank on `sad_done`. Backpressure to the mean stage uses `wr_ready`, which is low only while both banks hold lines not yet consumed.

## Interface
- `LINE_WIDTH`, 640: pixels per line (camera horizontal size); valid write addresses are 0..LINE_WIDTH-1.
- `MEAN_SIZE`, 8: width of one mean sample.
- `BUF_ADDR_WIDTH`, 10: width of write and read addresses; must satisfy 2^BUF_ADDR_WIDTH >= LINE_WIDTH.

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_data`  in  MEAN_SIZE  mean sample from the mean stage.
- `wr_addr`  in  BUF_ADDR_WIDTH  pixel index within the current line.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  buffer can accept a write this cycle.
- `line_ready`  out  1  a complete line is held in the read bank.
- `rd_en`  in  1  read request from the SAD engine.
- `rd_addr`  in  BUF_ADDR_WIDTH  pixel index to read from the read bank.
- `rd_data`  out  MEAN_SIZE  read result.
- `rd_valid`  out  1  `rd_data` is valid.
- `sad_done`  in  1  pulse: the SAD engine has finished with the read bank.
- `drop_count`  out  16  dropped-write counter; present only with `MEAN_BUF_DROP_CNT_EN`.

## Operation
- Two banks, each with its own state: FREE, FILL or FULL. The RAM is 2*LINE_WIDTH deep, and the bank bit is the address MSB.
- Pointers: `wr_ptr` selects the write bank and `rd_ptr` selects the read bank. Both reset to 0, and both banks reset to FREE.
- Write acceptance: a write is accepted when `wr_valid & wr_ready`.
  - The sample is stored at {wr_ptr, wr_addr}.
  - A FREE bank becomes FILL on its first accepted write.
- Line completion: an accepted write with `wr_addr == LINE_WIDTH-1` moves the write bank to FULL and toggles `wr_ptr`.
  - Writes need not arrive in address order. Completion is triggered only by the last address.
- Out-of-range writes (`wr_addr >= LINE_WIDTH`) are accepted with the handshake but not written, and they have no effect on bank state.
- `wr_ready` = (state[wr_ptr] != FULL).
- `line_ready` = (state[rd_ptr] == FULL).
- Reads: `rd_en` reads {rd_ptr, rd_addr} whether or not `line_ready` is high. The SAD engine is responsible for gating its reads.
- `sad_done` while `line_ready` is high: bank[rd_ptr] becomes FREE and `rd_ptr` toggles. `sad_done` while `line_ready` is low is ignored.
- Simultaneous events:
  - Line completion and `sad_done` in the same cycle both take effect.
  - If they target the same bank index, the bank being freed is the FULL read bank. The bank being completed is always the other one, so there is no conflict.
- Writes during FULL are impossible because `wr_ready` is low. A `wr_valid` while `wr_ready` is low is a dropped write (see Configuration).

## Timing
- All outputs are registered. Reset values: `wr_ready`=0, `line_ready`=0, `rd_valid`=0, `rd_data`=0, `drop_count`=0.
- `wr_ready` rises on the first cycle after `rst` deasserts.
- Final write accepted in cycle N: `line_ready` is high in N+1. If the other bank is FULL, `wr_ready` is low in N+1.
- `sad_done` in cycle M: `line_ready` reflects the next bank in M+1, and `wr_ready` reasserts in M+1 if it was low.
- Read latency is 1: `rd_en` in cycle R gives `rd_data` and `rd_valid` in R+1. `rd_valid` is low in any cycle not following an `rd_en`.
- Write-to-read on the same address in the same cycle cannot occur for a valid line, because the write and read banks differ whenever `line_ready` is high.
- `rst` asserted mid-line discards all bank contents and states. RAM data is not cleared.

## Configuration
- `MEAN_BUF_DROP_CNT_EN` defined:
  - `drop_count` port exists.
  - It increments by 1 on every cycle with `wr_valid & ~wr_ready`, and saturates at 16'hFFFF.
  - It is cleared by `rst`.
- Not defined: the port and the counter are absent, and dropped writes are silently ignored.

## Structure
- `mean_buf_pkg` holds:
  - `bank_state_t` enum (FREE, FILL, FULL).
  - `NUM_BANKS`=2.
  - `DROP_CNT_W`=16.
- One sub-module, `mean_line_ram`: a simple dual-port RAM (one write port, one registered read port) with depth 2*LINE_WIDTH and width MEAN_SIZE. It is inferable as block RAM.

## Test plan
- Reset, then write addresses 0..639 with data = addr[7:0] → `line_ready`=1 one cycle after address 639. Reading address 5 returns 8'h05 with `rd_valid` one cycle later.
- Fill two lines without `sad_done` → `wr_ready`=0 after the second line's address 639. Issue `sad_done` → `wr_ready`=1 next cycle, and `line_ready` stays 1 (bank 1 is now FULL).
- `sad_done` pulse with no FULL bank → no state change; `rd_ptr` stays 0.
- Write address 700 (out of range), then 0..639 → only one line completes, and address 700 corrupts nothing.
- With `MEAN_BUF_DROP_CNT_EN`: hold `wr_valid` for 3 cycles while both banks are FULL → `drop_count`=3.
- Assert `rst` after 300 writes → both banks FREE and `line_ready`=0. A fresh 640-write line then completes normally.
